// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg: state encoding, default timing and line levels shared by the UART
// transmitter and receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_STOP_BITS    = 1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// uart_baud_gen: free-running bit-period counter with synchronous clear.
// tick marks the last cycle of a bit; pre_tick marks the cycle before it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int             CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = !clear && (cnt_q == CNT_MAX);
  assign pre_tick = !clear && (cnt_q == CNT_PRE);

endmodule : uart_baud_gen

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx: 8N1-style serial transmitter with SEND/READY byte handshake.
// Optional parity bit when UART_TX_PARITY_EN is defined (PARITY_ODD selects).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int STOP_BITS    = DEFAULT_STOP_BITS
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 SEND,
  output logic                 READY,
  output logic                 Tx,
  output logic                 DONE
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 done_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_cnt_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  logic w_tick;
  logic w_pre_tick;

  // Counter is held at 0 while idle so each frame starts on a fresh bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (state_q == S_IDLE),
    .tick    (w_tick),
    .pre_tick(w_pre_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      tx_q      <= STOP_BIT;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (SEND && ready_q) begin
            shift_q   <= DATA;
`ifdef UART_TX_PARITY_EN
            par_q     <= (^DATA) ^ PARITY_ODD;
`endif
            tx_q      <= START_BIT;
            ready_q   <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q      <= par_q;
              state_q   <= S_PARITY;
`else
              tx_q      <= STOP_BIT;
              state_q   <= S_STOP;
`endif
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            tx_q      <= STOP_BIT;
            bit_cnt_q <= '0;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // DONE is registered, so it is raised one cycle ahead of the final tick.
          if (w_pre_tick && (bit_cnt_q == LAST_STOP)) begin
            done_q <= 1'b1;
          end
          if (w_tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          tx_q    <= STOP_BIT;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign READY = ready_q;
  assign Tx    = tx_q;
  assign DONE  = done_q;

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// tb_uart_tx: randomized self-checking bench for uart_tx with a frame-level
// reference model (expected line levels queued per accepted byte).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int         NBITS    = 11;
  localparam int         DONE_LIT = 44;
  localparam logic [10:0] A5_PAT  = 11'b10101001010;
`else
  localparam int         NBITS    = 10;
  localparam int         DONE_LIT = 40;
  localparam logic [10:0] A5_PAT  = 11'b01101001010;
`endif

  logic       CLK  = 1'b0;
  logic       RST  = 1'b1;
  logic       SEND = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       READY;
  logic       Tx;
  logic       DONE;

  always #5 CLK = ~CLK;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD  (1'b0)
`endif
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .DATA (DATA),
    .SEND (SEND),
    .READY(READY),
    .Tx   (Tx),
    .DONE (DONE)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue entry per expected line level per clock.
  logic q_line[$];
  logic exp_tx    = 1'b1;
  logic exp_ready = 1'b1;
  logic exp_done  = 1'b0;

  function automatic void push_frame(input logic [7:0] d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < CPB; c++) q_line.push_back(bits[i]);
    end
  endfunction

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      q_line.delete();
      exp_tx    = 1'b1;
      exp_ready = 1'b1;
      exp_done  = 1'b0;
    end else begin
      if (exp_ready && SEND) push_frame(DATA);
      if (q_line.size() != 0) begin
        exp_tx    = q_line.pop_front();
        exp_ready = 1'b0;
        exp_done  = (q_line.size() == 0);
      end else begin
        exp_tx    = 1'b1;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      chk("model_tx", Tx, exp_tx);
      chk("model_ready", READY, exp_ready);
      chk("model_done", DONE, exp_done);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic cap_tx [1:64];
  int   done_at;
  int   ready_at;
  logic [7:0] d5;

  task automatic wait_ready();
    int k = 0;
    while (!READY && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("ready_timeout", READY, 1);
  endtask

  // Sends d; optionally pulses SEND with 8'h3C at capture index pulse_at.
  task automatic send_capture(input logic [7:0] d, input int pulse_at);
    wait_ready();
    SEND     = 1'b1;
    DATA     = d;
    done_at  = 0;
    ready_at = 0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge CLK);
      SEND = (n == pulse_at);
      DATA = (n == pulse_at) ? 8'h3C : 8'($urandom);
      cap_tx[n] = Tx;
      if (DONE && done_at == 0) done_at = n;
      if (READY) begin
        ready_at = n;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_tx", Tx, 1);
    chk("rst_ready", READY, 1);
    chk("rst_done", DONE, 0);
    RST = 1'b0;

    // Idle after reset
    repeat (20) begin
      @(negedge CLK);
      chk("idle_tx", Tx, 1);
      chk("idle_ready", READY, 1);
      chk("idle_done", DONE, 0);
    end

    // Single frame 8'hA5
    send_capture(8'hA5, 0);
    for (int k = 0; k < NBITS; k++) begin
      chk($sformatf("a5_bit%0d", k), cap_tx[4*k+2], A5_PAT[k]);
    end
    chk("a5_done_cycle", done_at, DONE_LIT);
    chk("a5_ready_cycle", ready_at, DONE_LIT + 1);

    // Back-to-back frames with SEND held high
    wait_ready();
    SEND = 1'b1;
    DATA = 8'h00;
    @(negedge CLK);
    DATA = 8'hFF;
    begin
      int k = 0;
      while (!DONE && k < 100) begin
        @(negedge CLK);
        k++;
      end
      chk("b2b_first_done", DONE, 1);
    end
    @(negedge CLK);
    chk("b2b_gap_ready", READY, 1);
    chk("b2b_gap_tx", Tx, 1);
    @(negedge CLK);
    chk("b2b_second_ready", READY, 0);
    chk("b2b_second_start", Tx, 0);
    SEND = 1'b0;

    // Request while busy at data bit 3 is dropped
    send_capture(8'($urandom), 18);
    chk("busy_ready_cycle", ready_at, DONE_LIT + 1);
    repeat (5) begin
      @(negedge CLK);
      chk("busy_after_tx", Tx, 1);
      chk("busy_after_ready", READY, 1);
    end

    // Asynchronous reset during data bit 5
    wait_ready();
    d5   = 8'($urandom);
    SEND = 1'b1;
    DATA = d5;
    @(negedge CLK);
    SEND = 1'b0;
    repeat (25) @(negedge CLK);
    chk("pre_rst_bit5", Tx, d5[5]);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_tx", Tx, 1);
    chk("async_rst_ready", READY, 1);
    chk("async_rst_done", DONE, 0);
    @(negedge CLK);
    RST = 1'b0;
    send_capture(8'h96, 0);
    chk("post_rst_done_cycle", done_at, DONE_LIT);
    chk("post_rst_ready_cycle", ready_at, DONE_LIT + 1);

`ifdef UART_TX_PARITY_EN
    send_capture(8'h07, 0);
    chk("par07_parity_bit", cap_tx[38], 1);
    chk("par07_done_cycle", done_at, 44);
`endif

    // Randomized traffic with occasional resets
    repeat (2000) begin
      @(negedge CLK);
      SEND = ($urandom_range(0, 3) == 0);
      DATA = 8'($urandom);
      RST  = ($urandom_range(0, 399) == 0);
    end
    @(negedge CLK);
    SEND = 1'b0;
    RST  = 1'b0;
    wait_ready();
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_uart_tx

`default_nettype wire
